// File: rtl/alarm_sequencer.sv
// Arming/alarm sequencer: exit and entry delays, latched alarm, blinking LEDs
// and a seconds countdown for the 7-segment display path.
module alarm_sequencer #(
  parameter int TICKS_PER_SEC = 50,
  parameter int EXIT_S        = 30,
  parameter int ENTRY_S       = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mov,
  input  logic       pres,
  input  logic       temp_alta,
  output logic       led_en,
  output logic       led_pelig,
  output logic       disp_en,
  output logic [5:0] disp_val,
  output logic [2:0] estado
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICKS_PER_SEC / 2 - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  typedef enum logic [2:0] {
    S_DISARMED = 3'b000,
    S_EXIT     = 3'b001,
    S_ARMED    = 3'b010,
    S_ENTRY    = 3'b011,
    S_ALARM    = 3'b100
  } state_t;

  // Synchronizer bit order: {temp, pres, mov, en}
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          blink_q, blink_d;
  logic          led_en_q, led_en_d;
  logic          led_pelig_q, led_pelig_d;
  logic          disp_en_q, disp_en_d;
  logic [5:0]    disp_val_q, disp_val_d;

  logic en_s, mov_s, pres_s, temp_s;
  logic sec_tick, half_tick, expiry, chg;

  assign {temp_s, pres_s, mov_s, en_s} = sync2_q;
  assign sec_tick  = (presc_q == PRE_LAST);
  assign half_tick = (presc_q == PRE_HALF) || sec_tick;
  assign expiry    = sec_tick && (cnt_q == 6'd1);

  always_comb begin
    sync1_d = {temp_alta, pres, mov, en};
    sync2_d = sync1_q;

    state_d = state_q;
    if (temp_s) begin
      state_d = S_ALARM;
    end else if (!en_s && state_q != S_ALARM) begin
      state_d = S_DISARMED;
    end else begin
      case (state_q)
        S_DISARMED: if (en_s) state_d = S_EXIT;
        S_EXIT:     if (expiry) state_d = S_ARMED;
        S_ARMED: begin
          if (pres_s)     state_d = S_ALARM;
          else if (mov_s) state_d = S_ENTRY;
        end
        S_ENTRY:    if (expiry) state_d = S_ALARM;
        S_ALARM:    if (!en_s) state_d = S_DISARMED;
        default:    state_d = S_DISARMED;
      endcase
    end

    // Any state change realigns the prescaler and blink phase to a fresh second.
    chg     = (state_d != state_q);
    presc_d = (chg || sec_tick) ? '0 : presc_q + PRE_ONE;
    blink_d = chg ? 1'b1 : (half_tick ? ~blink_q : blink_q);

    case (state_d)
      S_EXIT:  cnt_d = chg ? 6'(EXIT_S)  : (sec_tick ? cnt_q - 6'd1 : cnt_q);
      S_ENTRY: cnt_d = chg ? 6'(ENTRY_S) : (sec_tick ? cnt_q - 6'd1 : cnt_q);
      default: cnt_d = 6'd0;
    endcase

    disp_en_d   = (state_d == S_EXIT) || (state_d == S_ENTRY);
    disp_val_d  = disp_en_d ? cnt_d : 6'd0;
    led_en_d    = (state_d == S_ARMED) || (disp_en_d && blink_d);
    led_pelig_d = (state_d == S_ALARM) && blink_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_q     <= S_DISARMED;
      presc_q     <= '0;
      cnt_q       <= '0;
      blink_q     <= 1'b0;
      led_en_q    <= 1'b0;
      led_pelig_q <= 1'b0;
      disp_en_q   <= 1'b0;
      disp_val_q  <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      blink_q     <= blink_d;
      led_en_q    <= led_en_d;
      led_pelig_q <= led_pelig_d;
      disp_en_q   <= disp_en_d;
      disp_val_q  <= disp_val_d;
    end
  end

  assign estado    = state_q;
  assign led_en    = led_en_q;
  assign led_pelig = led_pelig_q;
  assign disp_en   = disp_en_q;
  assign disp_val  = disp_val_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: a time-in-mode reference model queues
// the expected outputs each cycle and a separate monitor compares them.
module tb_alarm_sequencer;

  localparam int TPS = 4;
  localparam int EXS = 3;
  localparam int ENS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, mov, pres, temp_alta;
  logic       led_en, led_pelig, disp_en;
  logic [5:0] disp_val;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  alarm_sequencer #(
    .TICKS_PER_SEC(TPS),
    .EXIT_S(EXS),
    .ENTRY_S(ENS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mov(mov),
    .pres(pres),
    .temp_alta(temp_alta),
    .led_en(led_en),
    .led_pelig(led_pelig),
    .disp_en(disp_en),
    .disp_val(disp_val),
    .estado(estado)
  );

  // Expected outputs from the mode and the number of cycles spent in it.
  function automatic logic [11:0] expect_out(int m, int el);
    logic bl, de, le, lp;
    logic [5:0] dv;
    bl = ((el / (TPS / 2)) % 2) == 0;
    de = (m == 1) || (m == 3);
    dv = de ? 6'(((m == 1) ? EXS : ENS) - el / TPS) : 6'd0;
    le = (m == 2) || (de && bl);
    lp = (m == 4) && bl;
    return {3'(m), le, lp, de, dv};
  endfunction

  // Reference model: modes 0..4, inputs act two edges after being sampled.
  initial begin
    int mode, elapsed, nxt;
    logic [3:0] h0, h1;
    logic t, p, mv, e;
    mode = 0; elapsed = 0; h0 = '0; h1 = '0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        mode = 0; elapsed = 0; h0 = '0; h1 = '0;
      end else begin
        {t, p, mv, e} = h1;
        nxt = mode;
        if (t) nxt = 4;
        else if (!e && mode != 4) nxt = 0;
        else begin
          case (mode)
            0: if (e) nxt = 1;
            1: if (elapsed == EXS * TPS - 1) nxt = 2;
            2: if (p) nxt = 4; else if (mv) nxt = 3;
            3: if (elapsed == ENS * TPS - 1) nxt = 4;
            default: if (!e) nxt = 0;
          endcase
        end
        elapsed = (nxt != mode) ? 0 : elapsed + 1;
        mode = nxt;
        h1 = h0;
        h0 = {temp_alta, pres, mov, en};
      end
      exp_q.push_back(expect_out(mode, elapsed));
    end
  end

  initial begin
    logic [11:0] ex, act;
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      act = {estado, led_en, led_pelig, disp_en, disp_val};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cycle %0d: output %h with nothing expected", cyc, act);
      end else begin
        ex = exp_q.pop_front();
        if (act !== ex) begin
          errors++;
          $display("FAIL outputs cycle %0d: got estado=%0d led_en=%b led_pelig=%b disp_en=%b disp_val=%0d, want estado=%0d led_en=%b led_pelig=%b disp_en=%b disp_val=%0d",
                   cyc, act[11:9], act[8], act[7], act[6], act[5:0],
                   ex[11:9], ex[8], ex[7], ex[6], ex[5:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_now(input string nm);
    logic [11:0] act;
    #1;
    act = {estado, led_en, led_pelig, disp_en, disp_val};
    checks++;
    if (act !== 12'h000) begin
      errors++;
      $display("FAIL %s: got outputs %h, want 000 immediately on reset", nm, act);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mov = 1'b0; pres = 1'b0; temp_alta = 1'b0;
    check_reset_now("reset_at_start");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {en, mov, pres, temp_alta} = 4'($urandom);
    end
    @(negedge clk);
    en = 1'b0; mov = 1'b0; pres = 1'b0; temp_alta = 1'b0;
    rst = 1'b1;
    step(4);

    en = 1'b1;                       step(20);
    mov = 1'b1;                      step(1);
    mov = 1'b0;                      step(16);
    en = 1'b0;                       step(5);

    en = 1'b1;                       step(20);
    mov = 1'b1; pres = 1'b1;         step(1);
    mov = 1'b0; pres = 1'b0;         step(8);
    en = 1'b0;                       step(4);

    en = 1'b1;                       step(20);
    mov = 1'b1;                      step(1);
    mov = 1'b0;                      step(6);
    en = 1'b0;                       step(8);

    temp_alta = 1'b1;                step(6);
    temp_alta = 1'b0;                step(6);
    temp_alta = 1'b1;                step(3);
    en = 1'b1;                       step(3);
    en = 1'b0;                       step(3);
    temp_alta = 1'b0;                step(6);

    en = 1'b1;                       step(8);
    rst = 1'b0;
    check_reset_now("reset_mid_exit");
    step(2);
    rst = 1'b1;                      step(20);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      mov  = ($urandom_range(0, 19) == 0);
      pres = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 149) == 0) temp_alta = ~temp_alta;
    end
    rst = 1'b1; en = 1'b0; mov = 1'b0; pres = 1'b0; temp_alta = 1'b0;
    step(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
